color_mode_sequencer: RTL and testbench
=======================================

// Module: color_mode_sequencer
// PURPOSE
//  Sequences the 3-bit RGB color driving the pixel path: picks manual switch color, button-stepped palette,
//  auto-cycling palette, or blank. Drives expanded 8-bit R/G/B for each pixel with in_color set.
//  Color changes are committed only on frame start (vsync_pulse), so no frame tears. Sits between board I/O and VGA out.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  clk cycles a button level must hold stable before it is accepted (5 ms @ 50 MHz)
//  FRAMES_PER_STEP  60      vsync pulses between palette advances in AUTO mode (>=1)
// PORTS
//  clk          in   1  system clock; all state on rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  sw_r,sw_g,sw_b in 1  raw slide switches, manual color bits (asynchronous to clk)
//  btn_mode     in   1  raw push button, active-high: cycle mode
//  btn_next     in   1  raw push button, active-high: advance palette in STEP mode
//  vsync_pulse  in   1  one-cycle pulse at frame start, synchronous to clk
//  in_color     in   1  current pixel is foreground
//  red_out      out  8  red channel, registered
//  green_out    out  8  green channel, registered
//  blue_out     out  8  blue channel, registered
//  color_code   out  3  committed color {r,g,b}, registered
//  mode         out  2  current mode: 0 MANUAL, 1 STEP, 2 AUTO, 3 BLANK
// BEHAVIOUR
//  Reset (async assert, sync release): mode=MANUAL, pal_idx=3'd1, color_code=0, frame_cnt=0, all *_out=0,
//   debouncers stable=0, synchronizers cleared.
//  Inputs: sw_* pass through a 2-FF synchronizer; btn_* go through btn_debounce (2-FF sync + stability
//   counter); debouncer emits a 1-cycle rise pulse when its accepted level goes 0->1. Release never pulses.
//  Mode FSM, on mode_rise: MANUAL->STEP->AUTO->BLANK->MANUAL. Any mode change clears frame_cnt.
//  pal_idx (3 bit) cycles 1..7, wrap 7->1; value 0 (black) never reached. Kept across mode changes.
//   STEP: next_rise -> pal_idx+1. AUTO: on vsync_pulse frame_cnt++; at frame_cnt==FRAMES_PER_STEP-1
//   frame_cnt<=0 and pal_idx advances. MANUAL/BLANK: pal_idx holds, frame_cnt held at 0.
//  Simultaneous mode_rise and next_rise: mode change wins; next_rise discarded.
//  Candidate color: MANUAL={sw_r_s,sw_g_s,sw_b_s}; STEP/AUTO=pal_idx (register value); BLANK=3'b000.
//  Commit: color_code <= candidate only on cycle with vsync_pulse=1; holds otherwise. An advance in the
//   same cycle as vsync shows at the NEXT vsync (commit samples pre-update register value).
//  Output: each cycle, red_out <= (in_color & color_code[2]) ? 8'hFF : 8'h00; green uses [1], blue [0].
//   Latency in_color -> *_out: 1 clk. mode/color_code visible same cycle they are written.
//  FRAMES_PER_STEP=1: advance every vsync. Reset mid-frame: outputs drop to 0 immediately (async).
// STRUCTURE
//  Shared package color_pkg: mode encoding localparams MODE_MANUAL/STEP/AUTO/BLANK (2 bit), PAL_FIRST=3'd1,
//   PAL_LAST=3'd7, color-bit index constants R_BIT=2/G_BIT=1/B_BIT=0.
//  One sub-module btn_debounce #(DEBOUNCE_CYCLES) (clk, rst_n, btn_raw -> level, rise), instantiated twice.
//  Counter widths via $clog2 of each parameter; everything else in the top module.
// TESTING (bench uses DEBOUNCE_CYCLES=4, FRAMES_PER_STEP=3)
//  1 Reset: hold rst_n=0 with in_color=1, sw=3'b111 -> all *_out=0, mode=0, color_code=0; release, first
//    vsync -> color_code=3'b111, next cycle with in_color=1 -> red/green/blue_out=8'hFF.
//  2 Debounce: btn_mode glitch 2 cycles high -> mode stays 0; hold 10 cycles -> exactly one step, mode=1.
//  3 STEP wrap: mode=1, press btn_next 7 times from idx 1 -> idx 2..7 then 1; each color_code updates only
//    at the following vsync; in_color=0 forces *_out=0 regardless.
//  4 AUTO: mode=2, idx=5, issue 6 vsyncs -> idx 6 after 3rd, 7 after 6th; color_code trails by one vsync.
//  5 Collision: mode_rise and next_rise same cycle in STEP -> mode=2, idx unchanged; BLANK -> code 0 at vsync.
//  6 Reset mid-operation: assert rst_n in AUTO with frame_cnt=2 -> everything back to reset values async.

Source files
------------

// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - shared mode encodings, palette bounds and color-bit indices
package color_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'd0;
  localparam logic [1:0] MODE_STEP   = 2'd1;
  localparam logic [1:0] MODE_AUTO   = 2'd2;
  localparam logic [1:0] MODE_BLANK  = 2'd3;

  typedef enum logic [1:0] {
    ST_MANUAL = MODE_MANUAL,
    ST_STEP   = MODE_STEP,
    ST_AUTO   = MODE_AUTO,
    ST_BLANK  = MODE_BLANK
  } mode_e;

  localparam logic [2:0] PAL_FIRST = 3'd1;
  localparam logic [2:0] PAL_LAST  = 3'd7;

  localparam int R_BIT = 2;
  localparam int G_BIT = 1;
  localparam int B_BIT = 0;

  // Black (0) is skipped so the palette always shows something visible.
  function automatic logic [2:0] pal_next(input logic [2:0] idx);
    return (idx == PAL_LAST) ? PAL_FIRST : idx + 3'd1;
  endfunction

endpackage

// File: rtl/color_mode_sequencer_btn_debounce.sv
// rtl/color_mode_sequencer_btn_debounce.sv - 2-FF synchronizer plus stability counter for a raw button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d  = btn_raw;
    sync_d  = meta_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    // Count consecutive cycles the synced input disagrees with the accepted level.
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
        rise_d  = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/color_mode_sequencer.sv
// rtl/color_mode_sequencer.sv - selects manual/step/auto/blank color, commits it at frame start, drives RGB
module color_mode_sequencer
  import color_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FRAMES_PER_STEP = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_r,
  input  logic       sw_g,
  input  logic       sw_b,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       vsync_pulse,
  input  logic       in_color,
  output logic [7:0] red_out,
  output logic [7:0] green_out,
  output logic [7:0] blue_out,
  output logic [2:0] color_code,
  output logic [1:0] mode
);

  localparam int FRM_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES_PER_STEP - 1);

  logic mode_level, mode_rise;
  logic next_level, next_rise;
  logic unused_levels;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_mode),
    .level   (mode_level),
    .rise    (mode_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_next),
    .level   (next_level),
    .rise    (next_rise)
  );

  assign unused_levels = mode_level ^ next_level;

  logic [2:0]       sw_meta_q, sw_meta_d;
  logic [2:0]       sw_sync_q, sw_sync_d;
  mode_e            mode_q, mode_d;
  logic [2:0]       pal_q, pal_d;
  logic [FRM_W-1:0] frame_q, frame_d;
  logic [2:0]       code_q, code_d;
  logic [2:0]       candidate;
  logic [7:0]       red_q, red_d;
  logic [7:0]       green_q, green_d;
  logic [7:0]       blue_q, blue_d;

  always_comb begin
    sw_meta_d = {sw_r, sw_g, sw_b};
    sw_sync_d = sw_meta_q;
    mode_d    = mode_q;
    pal_d     = pal_q;
    frame_d   = frame_q;

    // A mode change takes priority and swallows any simultaneous palette step.
    if (mode_rise) begin
      frame_d = '0;
      case (mode_q)
        ST_MANUAL: mode_d = ST_STEP;
        ST_STEP:   mode_d = ST_AUTO;
        ST_AUTO:   mode_d = ST_BLANK;
        default:   mode_d = ST_MANUAL;
      endcase
    end else begin
      case (mode_q)
        ST_STEP: begin
          if (next_rise) pal_d = pal_next(pal_q);
        end
        ST_AUTO: begin
          if (vsync_pulse) begin
            if (frame_q == FRM_LAST) begin
              frame_d = '0;
              pal_d   = pal_next(pal_q);
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end
        end
        default: frame_d = '0;
      endcase
    end

    case (mode_q)
      ST_MANUAL:       candidate = sw_sync_q;
      ST_STEP, ST_AUTO: candidate = pal_q;
      default:         candidate = 3'b000;
    endcase

    // Commit uses the current register values, so a same-cycle advance lands a frame later.
    code_d = vsync_pulse ? candidate : code_q;

    red_d   = (in_color && code_q[R_BIT]) ? 8'hFF : 8'h00;
    green_d = (in_color && code_q[G_BIT]) ? 8'hFF : 8'h00;
    blue_d  = (in_color && code_q[B_BIT]) ? 8'hFF : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= 3'b000;
      sw_sync_q <= 3'b000;
      mode_q    <= ST_MANUAL;
      pal_q     <= PAL_FIRST;
      frame_q   <= '0;
      code_q    <= 3'b000;
      red_q     <= 8'h00;
      green_q   <= 8'h00;
      blue_q    <= 8'h00;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      mode_q    <= mode_d;
      pal_q     <= pal_d;
      frame_q   <= frame_d;
      code_q    <= code_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
    end
  end

  assign red_out    = red_q;
  assign green_out  = green_q;
  assign blue_out   = blue_q;
  assign color_code = code_q;
  assign mode       = mode_q;

endmodule

// File: tb/tb_color_mode_sequencer.sv
// tb/tb_color_mode_sequencer.sv - directed scoreboard bench for color_mode_sequencer
module tb_color_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw_r, sw_g, sw_b;
  logic       btn_mode, btn_next;
  logic       vsync_pulse;
  logic       in_color;
  logic [7:0] red_out, green_out, blue_out;
  logic [2:0] color_code;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  logic [1:0] em;
  logic [2:0] eidx;
  logic [2:0] ecode;

  color_mode_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .FRAMES_PER_STEP (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_r        (sw_r),
    .sw_g        (sw_g),
    .sw_b        (sw_b),
    .btn_mode    (btn_mode),
    .btn_next    (btn_next),
    .vsync_pulse (vsync_pulse),
    .in_color    (in_color),
    .red_out     (red_out),
    .green_out   (green_out),
    .blue_out    (blue_out),
    .color_code  (color_code),
    .mode        (mode)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_out(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%0h expected=<none>", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  task automatic check_state(input string tag);
    expect_val({tag, "_mode"}, {30'b0, em});
    check_out({30'b0, mode});
    expect_val({tag, "_code"}, {29'b0, ecode});
    check_out({29'b0, color_code});
  endtask

  function automatic logic [31:0] pix(input logic ic, input logic [2:0] c);
    return {8'h00, (ic & c[2]) ? 8'hFF : 8'h00, (ic & c[1]) ? 8'hFF : 8'h00,
            (ic & c[0]) ? 8'hFF : 8'h00};
  endfunction

  task automatic pixel(input string tag, input logic ic);
    in_color = ic;
    expect_val(tag, pix(ic, ecode));
    tick();
    check_out({8'h00, red_out, green_out, blue_out});
  endtask

  task automatic press(input logic pm, input logic pn);
    btn_mode = pm;
    btn_next = pn;
    tick(10);
    btn_mode = 1'b0;
    btn_next = 1'b0;
    tick(10);
  endtask

  task automatic vsync();
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
  endtask

  function automatic logic [2:0] model_next(input logic [2:0] i);
    return (i == 3'd7) ? 3'd1 : i + 3'd1;
  endfunction

  initial begin
    rst_n = 1'b0;
    {sw_r, sw_g, sw_b} = 3'b111;
    btn_mode = 1'b0;
    btn_next = 1'b0;
    vsync_pulse = 1'b0;
    in_color = 1'b1;
    em = 2'd0; eidx = 3'd1; ecode = 3'd0;

    // 1 reset and first commit
    tick(4);
    check_state("reset");
    expect_val("reset_pix", 32'h0);
    check_out({8'h00, red_out, green_out, blue_out});
    rst_n = 1'b1;
    tick(4);
    check_state("post_release");
    vsync();
    ecode = 3'b111;
    check_state("first_vsync");
    pixel("first_pix", 1'b1);

    // 2 debounce
    btn_mode = 1'b1;
    tick(2);
    btn_mode = 1'b0;
    tick(10);
    check_state("glitch");
    press(1'b1, 1'b0);
    em = 2'd1;
    check_state("mode_step");

    // 3 STEP wrap, commit only at vsync
    for (int i = 0; i < 7; i++) begin
      press(1'b0, 1'b1);
      eidx = model_next(eidx);
      check_state("step_pre_vsync");
      vsync();
      ecode = eidx;
      check_state("step_post_vsync");
      pixel("step_pix_off", 1'b0);
      pixel("step_pix_on", 1'b1);
    end

    // 4 AUTO from idx 5
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 1'b1);
      eidx = model_next(eidx);
    end
    press(1'b1, 1'b0);
    em = 2'd2;
    for (int v = 1; v <= 7; v++) begin
      vsync();
      ecode = eidx;
      if (v % 3 == 0) eidx = model_next(eidx);
      check_state("auto_vsync");
      tick(3);
    end
    // AUTO frame count is now 1; tour back to STEP (mode changes clear it)
    press(1'b1, 1'b0); em = 2'd3;
    press(1'b1, 1'b0); em = 2'd0;
    {sw_r, sw_g, sw_b} = 3'b101;
    tick(3);
    vsync();
    ecode = 3'b101;
    check_state("manual_sw");
    press(1'b1, 1'b0); em = 2'd1;

    // 5 collision: mode wins, palette untouched
    press(1'b1, 1'b1);
    em = 2'd2;
    vsync();
    ecode = eidx;
    check_state("collision");
    press(1'b1, 1'b0); em = 2'd3;
    vsync();
    ecode = 3'b000;
    check_state("blank");
    pixel("blank_pix", 1'b1);

    // 6 async reset in AUTO with frame_cnt=2
    press(1'b1, 1'b0); em = 2'd0;
    press(1'b1, 1'b0); em = 2'd1;
    press(1'b1, 1'b0); em = 2'd2;
    vsync(); ecode = eidx; tick(2);
    vsync(); tick(2);
    check_state("auto_before_reset");
    pixel("auto_pix", 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    em = 2'd0; eidx = 3'd1; ecode = 3'd0;
    check_state("async_reset");
    expect_val("async_reset_pix", 32'h0);
    check_out({8'h00, red_out, green_out, blue_out});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
    press(1'b1, 1'b0); em = 2'd1;
    vsync();
    ecode = eidx;
    check_state("pal_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
